// File: rtl/mux_scan_reg.sv
// mux_scan_reg: N-channel, W-bit registered multiplexer with a valid/ready
// output, a manual-select mode and a round-robin auto-scan mode. The
// captured channel index is reported alongside the data.
//
// Optional build macro: MUX_SCAN_MASK_EN
//   When defined, the extra input chan_mask[N-1:0] is added. A 1 enables a
//   channel. Scan mode skips disabled channels, searching forward with wrap.
//   Manual mode treats a disabled sel like an out-of-range sel.
//   When undefined, every channel is always enabled.
//
// Output handshake (valid/ready):
//   out_valid=1 means out_data/out_ch hold a sample not yet consumed. The
//   sample is consumed at a rising edge where out_valid && out_ready. While
//   out_valid && !out_ready, out_data/out_ch are frozen and en is ignored.
//   Ignored requests are neither queued nor reported. A new capture may land
//   in the same edge that consumes the old sample, so holding out_ready=1
//   streams one sample per cycle.
module mux_scan_reg #(
  parameter int N    = 8,
  parameter int W    = 1,
  parameter int SELW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  din,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            en,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]    chan_mask,
`endif
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  output logic [SELW-1:0] out_ch,
  output logic            sel_err
);

  // Channel count and last index expressed in select-width arithmetic.
  localparam logic [SELW:0]   N_EXT   = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST_CH = SELW'(N-1);

  logic [SELW-1:0] ptr;
  logic            mode_q;

  logic [N-1:0]    enabled;
  logic            cap_ok;
  logic            scan_entry;
  logic [SELW-1:0] eff_ptr;
  logic            man_en;
  logic            man_legal;
  logic            scan_found;
  logic [SELW-1:0] scan_ch;
  logic [SELW-1:0] cap_ch;
  logic            cap_legal;
  logic            capture;
  logic [W-1:0]    cap_data;
  logic [SELW-1:0] ptr_after;

`ifdef MUX_SCAN_MASK_EN
  assign enabled = chan_mask;
`else
  assign enabled = '1;
`endif

  // A capture slot exists when requested and the output register is free
  // or is being emptied at this very edge.
  assign cap_ok = en && (!out_valid || out_ready);

  // Entering scan mode restarts the round-robin at channel 0.
  assign scan_entry = mode && !mode_q;
  assign eff_ptr    = scan_entry ? '0 : ptr;

  // Manual select: look up the enable bit of the selected channel.
  always_comb begin
    man_en = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == k[SELW-1:0]) man_en = enabled[k];
    end
  end

  assign man_legal = ({1'b0, sel} < N_EXT) && man_en;

  // Scan search: first enabled channel at or after eff_ptr, wrapping at N.
  // With every channel enabled this always returns eff_ptr itself.
  always_comb begin
    int idx;
    idx        = 0;
    scan_found = 1'b0;
    scan_ch    = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(eff_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!scan_found && enabled[idx]) begin
        scan_found = 1'b1;
        scan_ch    = idx[SELW-1:0];
      end
    end
  end

  assign cap_ch    = mode ? scan_ch : sel;
  assign cap_legal = mode ? scan_found : man_legal;
  assign capture   = cap_ok && cap_legal;

  // Pointer resumes just past the channel that was taken, wrapping N-1 -> 0.
  assign ptr_after = (scan_ch == LAST_CH) ? '0 : scan_ch + SELW'(1);

  // Data mux: pick the W-bit slice of the chosen channel.
  always_comb begin
    cap_data = '0;
    for (int k = 0; k < N; k++) begin
      if (cap_ch == k[SELW-1:0]) cap_data = din[k*W +: W];
    end
  end

  // Output register, valid flag, error pulse, scan pointer and mode history.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      sel_err   <= 1'b0;
      ptr       <= '0;
      mode_q    <= 1'b0;
    end else begin
      mode_q  <= mode;
      // Only a manual request that actually had a slot can be refused.
      sel_err <= cap_ok && !mode && !man_legal;

      if (capture) begin
        out_data  <= cap_data;
        out_ch    <= cap_ch;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A scan entry with no capture still restarts at 0, so the first scan
      // capture after entry is always the lowest eligible channel from 0.
      if (capture && mode) begin
        ptr <= ptr_after;
      end else if (scan_entry) begin
        ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: an N=8/W=4 instance checked every cycle against a
// behavioural model plus directed literal checks, and an N=6 instance for
// out-of-range select handling.
module tb_mux_scan_reg;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int SW = 3;
  localparam int N6 = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // ---------------- DUT (N=8) ----------------
  logic [N*W-1:0] din;
  logic [SW-1:0]  sel;
  logic           mode, en, out_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [SW-1:0]  out_ch;
  logic           sel_err;
`ifdef MUX_SCAN_MASK_EN
  logic [N-1:0]   chan_mask = '1;
  logic [N6-1:0]  chan_mask6 = '1;
`endif

  mux_scan_reg #(.N(N), .W(W), .SELW(SW)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_SCAN_MASK_EN
    .chan_mask(chan_mask),
`endif
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ch(out_ch), .sel_err(sel_err)
  );

  // ---------------- DUT (N=6) ----------------
  logic [N6*W-1:0] din6;
  logic [SW-1:0]   sel6;
  logic            mode6, en6, ready6;
  logic [W-1:0]    data6;
  logic            valid6;
  logic [SW-1:0]   ch6;
  logic            err6;

  mux_scan_reg #(.N(N6), .W(W), .SELW(SW)) dut6 (
    .clk(clk), .rst(rst), .din(din6), .sel(sel6), .mode(mode6), .en(en6),
`ifdef MUX_SCAN_MASK_EN
    .chan_mask(chan_mask6),
`endif
    .out_ready(ready6), .out_data(data6), .out_valid(valid6),
    .out_ch(ch6), .sel_err(err6)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  // ---------------- behavioural model (N=8 instance) ----------------
  // Holds "the sample currently on offer" and "the next round-robin channel".
  int m_data, m_ch, m_ptr;
  bit m_valid, m_err, m_prev_mode;
  bit m_slot, m_ok;
  int m_pick;

  always @(posedge clk) begin
    if (rst) begin
      m_data = 0; m_ch = 0; m_ptr = 0;
      m_valid = 0; m_err = 0; m_prev_mode = 0;
    end else begin
      m_slot = en && (!m_valid || out_ready);
      if (mode) begin
        m_pick = m_prev_mode ? m_ptr : 0;
        m_ok   = 1'b1;
      end else begin
        m_pick = int'(sel);
        m_ok   = (int'(sel) < N);
      end
      if (m_slot && m_ok) begin
        m_valid = 1'b1;
        m_data  = int'(din[m_pick*W +: W]);
        m_ch    = m_pick;
        if (mode) m_ptr = (m_pick + 1) % N;
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (mode && !m_prev_mode) m_ptr = 0;
      end
      m_err       = m_slot && !m_ok;
      m_prev_mode = mode;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      n_cmp += 4;
      if (out_valid !== m_valid) begin
        n_bad++;
        $display("FAIL model out_valid t=%0t got %0b want %0b", $time, out_valid, m_valid);
      end
      if (int'(out_data) != m_data || $isunknown(out_data)) begin
        n_bad++;
        $display("FAIL model out_data t=%0t got %0h want %0h", $time, out_data, m_data);
      end
      if (int'(out_ch) != m_ch || $isunknown(out_ch)) begin
        n_bad++;
        $display("FAIL model out_ch t=%0t got %0d want %0d", $time, out_ch, m_ch);
      end
      if (sel_err !== m_err) begin
        n_bad++;
        $display("FAIL model sel_err t=%0t got %0b want %0b", $time, sel_err, m_err);
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if ($isunknown(act) || int'(act) != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic set_din_plus3();
    for (int k = 0; k < N; k++) din[k*W +: W] = W'(k + 3);
  endtask

  int exp_scan [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; en = 0; mode = 0; sel = '0; out_ready = 0;
    set_din_plus3();
    for (int k = 0; k < N6; k++) din6[k*W +: W] = W'(2*k + 1);
    sel6 = '0; mode6 = 0; en6 = 0; ready6 = 0;
    step(); step();
    cmp_on = 1'b1;
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_data",  32'(out_data),  0);
    chk("reset_ch",    32'(out_ch),    0);
    chk("reset_err",   32'(sel_err),   0);
    rst = 1'b0;

    // Manual select sweep: channel k carries k+3.
    out_ready = 1; en = 1; mode = 0;
    for (int s = 0; s < N; s++) begin
      sel = SW'(s);
      step();
      chk("manual_data",  32'(out_data),  s + 3);
      chk("manual_ch",    32'(out_ch),    s);
      chk("manual_valid", 32'(out_valid), 1);
    end

    // Drain with no request.
    en = 0;
    step();
    chk("drain_valid", 32'(out_valid), 0);

    // Scan wrap over 10 captures.
    mode = 1; en = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("scan_ch",   32'(out_ch),   exp_scan[i]);
      chk("scan_data", 32'(out_data), exp_scan[i] + 3);
    end

    // Reset in the middle of a scan stream.
    for (int i = 0; i < 5; i++) step();
    rst = 1;
    step();
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_data",  32'(out_data),  0);
    chk("midrst_ch",    32'(out_ch),    0);
    rst = 0;
    step();
    chk("postrst_ch",   32'(out_ch),   0);
    chk("postrst_data", 32'(out_data), 3);
    step();
    chk("postrst_ch1", 32'(out_ch), 1);
    step();
    chk("bp_cap_ch",   32'(out_ch),   2);
    chk("bp_cap_data", 32'(out_data), 5);

    // Back-pressure: output frozen while din churns and en stays high.
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      din = N*W'($urandom);
      step();
      chk("bp_hold_ch",    32'(out_ch),    2);
      chk("bp_hold_data",  32'(out_data),  5);
      chk("bp_hold_valid", 32'(out_valid), 1);
    end
    din = {N{4'hA}};
    out_ready = 1;
    step();
    chk("bp_release_ch",   32'(out_ch),   3);
    chk("bp_release_data", 32'(out_data), 10);
    step();
    chk("bp_next_ch", 32'(out_ch), 4);

    // Mode change while a sample is held does not touch it.
    out_ready = 0; mode = 0; sel = 3'd7;
    step();
    chk("modechg_ch",    32'(out_ch),    4);
    chk("modechg_valid", 32'(out_valid), 1);
    out_ready = 1; en = 0;
    step();
    chk("modechg_drain", 32'(out_valid), 0);
    mode = 1; en = 1;
    step();
    chk("reentry_ch", 32'(out_ch), 0);

    // Scan entry with no request still restarts at channel 0.
    mode = 0; en = 0;
    step();
    mode = 1;
    step();
    en = 1;
    step();
    chk("idle_entry_ch", 32'(out_ch), 0);
    en = 0;
    step();

    // N=6 instance: out-of-range selects.
    en6 = 1; sel6 = 3'd7; ready6 = 1;
    step();
    chk("ill7_err",   32'(err6),   1);
    chk("ill7_valid", 32'(valid6), 0);
    en6 = 0;
    step();
    chk("ill7_pulse_end", 32'(err6), 0);
    en6 = 1; sel6 = 3'd5;
    step();
    chk("n6_last_valid", 32'(valid6), 1);
    chk("n6_last_ch",    32'(ch6),    5);
    chk("n6_last_data",  32'(data6),  11);
    chk("n6_last_err",   32'(err6),   0);
    ready6 = 0; sel6 = 3'd6;
    step();
    chk("ill6_blocked_err",  32'(err6),   0);
    chk("ill6_blocked_hold", 32'(ch6),    5);
    ready6 = 1;
    step();
    chk("ill6_err",   32'(err6),   1);
    chk("ill6_drain", 32'(valid6), 0);
    en6 = 0;
    step();
    chk("ill6_pulse_end", 32'(err6), 0);

    step();
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Parametrised N-channel, W-bit-wide registered multiplexer.
- Successor to the team's fixed 8:1 single-bit combinational mux tree.
- Adds a registered output with a valid/ready handshake, a manual-select mode and an auto-scan (round-robin) mode, and reports the captured channel number.
- Sits between a bank of parallel sample sources and a single serial consumer.

Parameters:
- N, 8, number of input channels (2..256).
- W, 1, bit width of each channel.
- SELW, 3, select/channel-index width; must satisfy 2**SELW >= N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  N*W  packed channel data; channel k is din[k*W +: W].
- sel  input  SELW  channel select, used in manual mode only.
- mode  input  1  0 = manual select, 1 = auto-scan.
- en  input  1  capture request.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  W  registered selected channel data.
- out_valid  output  1  out_data/out_ch hold an unconsumed sample.
- out_ch  output  SELW  index of the channel captured into out_data.
- sel_err  output  1  one-cycle pulse on a refused manual capture.

Behaviour:
- Reset (rst=1 at a clk edge): out_data=0, out_valid=0, out_ch=0, sel_err=0, scan pointer ptr=0, mode_q=0. Reset overrides any capture or handshake in the same cycle.
- Capture slot: cap_ok = en && (!out_valid || out_ready).
  - Full-throughput streaming is required when out_ready is held at 1.
- Channel choice:
  - Manual mode: ch = sel.
  - Scan mode: ch = ptr.
- Capture (cap_ok and ch legal): at the next edge out_data <= din[ch], out_ch <= ch, out_valid <= 1. Latency is exactly 1 cycle from en to out_valid.
- Output drain: if out_valid && out_ready && !cap_ok-capture, out_valid <= 0 at the next edge. Simultaneous drain and capture keeps out_valid=1 and loads the new sample.
- Back-pressure: while out_valid=1 and out_ready=0, out_data and out_ch are frozen and en is ignored. Ignored requests are not queued and are not counted as errors.
- Manual illegal select: if sel >= N and cap_ok, there is no capture and out_valid follows drain rules only. sel_err pulses high for exactly one cycle.
- Scan pointer:
  - Advances only on a successful scan-mode capture: ptr <= (ptr == N-1) ? 0 : ptr + 1. It wraps N-1 -> 0.
  - Unchanged in manual mode.
  - mode_q registers mode each cycle. A 0->1 transition (mode=1, mode_q=0) forces the effective ptr to 0 for that cycle's capture. The first scan capture after entering scan mode is always channel 0.
- A mode change while out_valid=1 does not alter the held sample.
- Internal state: ptr, mode_q, out regs. No FSM beyond the valid flag.

Optional Feature:
- Macro: MUX_SCAN_MASK_EN.
- When defined, an extra input port chan_mask [N-1:0] is added (1 = channel enabled).
- Scan mode: capture takes the first enabled channel at or after ptr, searching with wrap. ptr then becomes that channel + 1, with wrap.
  - If chan_mask = 0, there is no capture and no error.
- Manual mode: a masked sel is treated like sel >= N (no capture, sel_err pulse).
- When not defined: the port is absent and all channels are always enabled. Behaviour is exactly as above.

Test Plan:
- Reset mid-stream: N=8, W=4, streaming in scan mode, assert rst on cycle 5 -> next cycle out_valid=0, out_data=0, out_ch=0; next scan capture is channel 0.
- Manual select: din channels k=k+3 (W=4), mode=0, out_ready=1, en=1, sel=0..7 -> out_data=3..10 and out_ch=sel, each exactly one cycle after the matching sel.
- Scan wrap: mode=1, en=1, out_ready=1 for 10 cycles -> out_ch sequence 0,1,...,7,0,1.
- Back-pressure: capture channel 2, then out_ready=0 for 4 cycles with en=1 and din changing -> out_data and out_ch held, ptr stays 3. out_ready=1 -> next capture is channel 3, with no gap cycle.
- Illegal select: N=6, SELW=3, mode=0, sel=7, en=1 -> sel_err=1 for one cycle, out_valid unchanged.
- Mask (MUX_SCAN_MASK_EN): N=8, chan_mask=8'b1010_0100, scan for 5 captures -> out_ch 2,5,7,2,5; chan_mask=0 -> no captures and sel_err stays 0.
